call_scheduler: RTL and testbench
=================================

# call_scheduler

Holds elevator call requests from the input processor until they are served and decides travel direction and next target floor. Sits between the input processor (one-cycle set pulses on up/down/cabin call vectors) and the status-transition controller (reports current floor and arrival). Pending vectors also feed the display LEDs.

## Interface
Parameters:
- none. Fixed at 8 floors (indices 0-7) with a 3-bit floor number.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `up_call`  in  8  one-cycle set pulses, hall up call per floor.
- `down_call`  in  8  one-cycle set pulses, hall down call per floor.
- `floor_btn_in`  in  8  one-cycle set pulses, cabin floor buttons.
- `floor`  in  3  current elevator floor.
- `arrived`  in  1  one-cycle pulse: cabin stopped at `floor` with door opening.
- `up_pending`  out  8  registered pending hall-up requests.
- `down_pending`  out  8  registered pending hall-down requests.
- `cab_pending`  out  8  registered pending cabin requests.
- `dir`  out  2  travel direction: 00 IDLE, 01 UP, 10 DOWN. 11 is never driven.
- `target`  out  3  next floor to stop at.
- `target_valid`  out  1  high when any request is pending.
- `served`  out  1  one-cycle pulse: an arrival cleared at least one request.

## Operation
- Masking:
  - `up_call[7]` and `down_call[0]` are ignored; the corresponding pending bits stay 0.
- Pending registers:
  - Each register updates as `pending <= (pending & ~clr) | set`.
  - `set` is the masked input pulse vector.
  - `clr` is nonzero only in a cycle with `arrived` high.
- Clear on `arrived` (only bit `floor` is affected):
  - `cab_pending[floor]` is always cleared.
  - If `dir` is UP, clear `up_pending[floor]`.
  - If `dir` is DOWN, clear `down_pending[floor]`.
  - If `dir` is IDLE, clear both hall bits.
  - Turnaround: if `dir` is UP and no request of any type exists above `floor`, also clear `down_pending[floor]`. The mirror rule applies for DOWN with nothing below.
- Simultaneous set and clear of the same bit: set wins, so the bit stays 1.
- Derived signals (computed from the registered pending vectors):
  - `all = up_pending | down_pending | cab_pending`.
  - `any_above` is true if any bit of `all` at an index greater than `floor` is set.
  - `any_below` is true if any bit of `all` at an index less than `floor` is set.
  - `here` is `all[floor]`.
- Direction FSM, states IDLE / UP / DOWN:
  - IDLE: go to UP if `any_above`; else go to DOWN if `any_below`; else stay IDLE. `here` alone keeps the state IDLE.
  - UP: stay UP if `any_above`; else go to DOWN if `any_below`; else go to IDLE.
  - DOWN: stay DOWN if `any_below`; else go to UP if `any_above`; else go to IDLE.
- Target selection (registered, uses the next-state direction):
  - UP: lowest set index of `all` above `floor`.
  - DOWN: highest set index of `all` below `floor`.
  - IDLE: `floor` if `here` is set; otherwise `target` holds its previous value.
  - `target_valid` is `|all` of the next pending state. When it is 0, `target` holds.
- `served`: registered. It goes high for one cycle when `arrived` was high and the clear vector hit at least one set bit.
- `floor` values are always 0-7; no out-of-range handling is needed.

## Timing
- Reset (async assert, sync release) drives:
  - all pending vectors to 0,
  - `dir` to IDLE (00),
  - `target` to 0,
  - `target_valid` to 0,
  - `served` to 0.
- Set pulse sampled at edge N: the pending bit and `target_valid` are visible after edge N.
- `dir` and `target` reflect that request after edge N+1, i.e. 1 cycle after the pending change.
- `arrived` sampled at edge N:
  - the bits clear after edge N;
  - `served` is high for the cycle after edge N;
  - `dir` and `target` update after edge N+1.
- Reset asserted mid-operation: all state is lost immediately; pulses arriving during reset are dropped.
- No handshake: input pulses are single-cycle. A level held for k cycles is equivalent to one pulse.

## Test plan
- Reset behaviour: reset, then pulse `floor_btn_in=8'b0010_0000` with `floor=0` -> `cab_pending=8'h20` and `target_valid=1` after 1 edge; `dir=01` and `target=5` after 2 edges.
- Masking: pulse `up_call=8'h80` and `down_call=8'h01` -> both pending vectors stay 0, `target_valid=0`, `dir=00`.
- Directional clear: `floor=3`, `dir=UP`, with `up_pending=8'h08`, `down_pending=8'h08` and `cab_pending=8'h40`; pulse `arrived` -> `up_pending=0`, `down_pending=8'h08` retained, `served=1` for one cycle, `target=6`.
- Turnaround: `floor=6`, `dir=UP`, `down_pending=8'h41`, nothing else pending; pulse `arrived` -> `down_pending=8'h01`, then `dir=10` and `target=0`.
- Set-wins collision: `floor=2`, `dir=IDLE`, `cab_pending=8'h04`; assert `arrived` and `floor_btn_in=8'h04` in the same cycle -> `cab_pending` stays `8'h04`, and `served=1`.
- Async reset mid-travel: with `dir=01` and 3 requests pending, pulse `rst` between clock edges -> all outputs go to their reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/call_scheduler.sv
// Elevator call scheduler: latches hall/cabin requests, clears them on arrival,
// and picks the travel direction and the next floor to stop at.
module call_scheduler (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] up_call,
  input  logic [7:0] down_call,
  input  logic [7:0] floor_btn_in,
  input  logic [2:0] floor,
  input  logic       arrived,
  output logic [7:0] up_pending,
  output logic [7:0] down_pending,
  output logic [7:0] cab_pending,
  output logic [1:0] dir,
  output logic [2:0] target,
  output logic       target_valid,
  output logic       served
);

  typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, DN = 2'b10} dir_e;

  dir_e       state, state_nxt;
  logic [7:0] all, above_mask, below_mask, onehot;
  logic [7:0] up_set, dn_set, up_clr, dn_clr, cab_clr;
  logic [7:0] up_nxt, dn_nxt, cab_nxt;
  logic       any_above, any_below, here, hit;
  logic [2:0] lo_above, hi_below;

  // Top floor has no up call, bottom floor has no down call.
  assign up_set     = up_call & 8'h7F;
  assign dn_set     = down_call & 8'hFE;
  assign all        = up_pending | down_pending | cab_pending;
  assign above_mask = 8'hFE << floor;
  assign below_mask = ~(8'hFF << floor);
  assign onehot     = 8'd1 << floor;
  assign any_above  = |(all & above_mask);
  assign any_below  = |(all & below_mask);
  assign here       = all[floor];
  assign dir        = state;

  always_comb begin
    lo_above = 3'd0;
    hi_below = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (all[i] && above_mask[i]) lo_above = 3'(i);
    for (int i = 0; i < 8; i++)
      if (all[i] && below_mask[i]) hi_below = 3'(i);
  end

  always_comb begin
    cab_clr = 8'd0;
    up_clr  = 8'd0;
    dn_clr  = 8'd0;
    if (arrived) begin
      cab_clr = onehot;
      case (state)
        UP:      begin up_clr = onehot; if (!any_above) dn_clr = onehot; end
        DN:      begin dn_clr = onehot; if (!any_below) up_clr = onehot; end
        default: begin up_clr = onehot; dn_clr = onehot; end
      endcase
    end
  end

  assign up_nxt  = (up_pending   & ~up_clr)  | up_set;
  assign dn_nxt  = (down_pending & ~dn_clr)  | dn_set;
  assign cab_nxt = (cab_pending  & ~cab_clr) | floor_btn_in;
  assign hit     = |((up_pending & up_clr) | (down_pending & dn_clr) | (cab_pending & cab_clr));

  always_comb begin
    state_nxt = IDLE;
    case (state)
      UP:      state_nxt = any_above ? UP : (any_below ? DN : IDLE);
      DN:      state_nxt = any_below ? DN : (any_above ? UP : IDLE);
      default: state_nxt = any_above ? UP : (any_below ? DN : IDLE);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_pending   <= 8'd0;
      down_pending <= 8'd0;
      cab_pending  <= 8'd0;
      state        <= IDLE;
      target       <= 3'd0;
      target_valid <= 1'b0;
      served       <= 1'b0;
    end else begin
      up_pending   <= up_nxt;
      down_pending <= dn_nxt;
      cab_pending  <= cab_nxt;
      state        <= state_nxt;
      target_valid <= |(up_nxt | dn_nxt | cab_nxt);
      served       <= arrived & hit;
      // Target follows the direction being entered; idle with nothing here holds.
      case (state_nxt)
        UP:      target <= lo_above;
        DN:      target <= hi_below;
        default: if (here) target <= floor;
      endcase
    end
  end

endmodule

// File: tb/tb_call_scheduler.sv
// Directed bench for call_scheduler: stimulus pushes expected output snapshots,
// a monitor process pops and compares them against the DUT.
module tb_call_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] up_call = '0, down_call = '0, floor_btn_in = '0;
  logic [2:0] floor = '0;
  logic       arrived = 1'b0;
  logic [7:0] up_pending, down_pending, cab_pending;
  logic [1:0] dir;
  logic [2:0] target;
  logic       target_valid, served;

  call_scheduler dut (
    .clk(clk), .rst(rst), .up_call(up_call), .down_call(down_call),
    .floor_btn_in(floor_btn_in), .floor(floor), .arrived(arrived),
    .up_pending(up_pending), .down_pending(down_pending), .cab_pending(cab_pending),
    .dir(dir), .target(target), .target_valid(target_valid), .served(served)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] up, dn, cab;
    logic [1:0] dir;
    logic [2:0] tgt;
    logic       tv, srv;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  event  chk_ev;
  int    checks = 0, failures = 0;

  always begin
    @(chk_ev);
    while (exp_q.size() > 0) begin
      snap_t e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{up_pending, down_pending, cab_pending, dir, target, target_valid, served};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got up=%h dn=%h cab=%h dir=%b tgt=%0d tv=%b srv=%b, want up=%h dn=%h cab=%h dir=%b tgt=%0d tv=%b srv=%b",
                 n, a.up, a.dn, a.cab, a.dir, a.tgt, a.tv, a.srv,
                 e.up, e.dn, e.cab, e.dir, e.tgt, e.tv, e.srv);
      end
    end
  end

  task automatic expect_snap(input string n, input logic [7:0] up, dn, cab,
                             input logic [1:0] d, input logic [2:0] t,
                             input logic tv, srv);
    exp_q.push_back('{up, dn, cab, d, t, tv, srv});
    name_q.push_back(n);
    -> chk_ev;
    #0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] u, dn, c, input logic arr);
    up_call = u; down_call = dn; floor_btn_in = c; arrived = arr;
    tick();
    up_call = '0; down_call = '0; floor_btn_in = '0; arrived = 1'b0;
  endtask

  task automatic do_reset(input logic [2:0] f);
    rst = 1'b1;
    floor = f;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset, then cabin call to floor 5 from floor 0
    do_reset(3'd0);
    expect_snap("reset_state", 8'h00, 8'h00, 8'h00, 2'b00, 3'd0, 1'b0, 1'b0);
    pulse(8'h00, 8'h00, 8'h20, 1'b0);
    expect_snap("cab5_pending", 8'h00, 8'h00, 8'h20, 2'b00, 3'd0, 1'b1, 1'b0);
    tick();
    expect_snap("cab5_dir_up", 8'h00, 8'h00, 8'h20, 2'b01, 3'd5, 1'b1, 1'b0);

    // Masked hall calls
    do_reset(3'd0);
    pulse(8'h80, 8'h01, 8'h00, 1'b0);
    expect_snap("mask_edge1", 8'h00, 8'h00, 8'h00, 2'b00, 3'd0, 1'b0, 1'b0);
    tick();
    expect_snap("mask_edge2", 8'h00, 8'h00, 8'h00, 2'b00, 3'd0, 1'b0, 1'b0);

    // Directional clear at floor 3 while going up to 6
    do_reset(3'd3);
    pulse(8'h08, 8'h08, 8'h40, 1'b0);
    expect_snap("dclr_setup1", 8'h08, 8'h08, 8'h40, 2'b00, 3'd0, 1'b1, 1'b0);
    tick();
    expect_snap("dclr_setup2", 8'h08, 8'h08, 8'h40, 2'b01, 3'd6, 1'b1, 1'b0);
    pulse(8'h00, 8'h00, 8'h00, 1'b1);
    expect_snap("dclr_arrive", 8'h00, 8'h08, 8'h40, 2'b01, 3'd6, 1'b1, 1'b1);
    tick();
    expect_snap("dclr_after", 8'h00, 8'h08, 8'h40, 2'b01, 3'd6, 1'b1, 1'b0);

    // Turnaround at floor 6 with down calls at 6 and 1
    do_reset(3'd0);
    pulse(8'h00, 8'h42, 8'h00, 1'b0);
    expect_snap("turn_setup1", 8'h00, 8'h42, 8'h00, 2'b00, 3'd0, 1'b1, 1'b0);
    tick();
    expect_snap("turn_setup2", 8'h00, 8'h42, 8'h00, 2'b01, 3'd1, 1'b1, 1'b0);
    floor = 3'd6;
    pulse(8'h00, 8'h00, 8'h00, 1'b1);
    expect_snap("turn_arrive", 8'h00, 8'h02, 8'h00, 2'b10, 3'd1, 1'b1, 1'b1);
    tick();
    expect_snap("turn_after", 8'h00, 8'h02, 8'h00, 2'b10, 3'd1, 1'b1, 1'b0);

    // Set-wins collision at floor 2 while idle
    do_reset(3'd2);
    pulse(8'h00, 8'h00, 8'h04, 1'b0);
    tick();
    expect_snap("coll_setup", 8'h00, 8'h00, 8'h04, 2'b00, 3'd2, 1'b1, 1'b0);
    pulse(8'h00, 8'h00, 8'h04, 1'b1);
    expect_snap("coll_arrive", 8'h00, 8'h00, 8'h04, 2'b00, 3'd2, 1'b1, 1'b1);
    tick();
    expect_snap("coll_after", 8'h00, 8'h00, 8'h04, 2'b00, 3'd2, 1'b1, 1'b0);

    // Async reset mid-travel; a pulse during reset is dropped
    do_reset(3'd0);
    pulse(8'h08, 8'h80, 8'h20, 1'b0);
    tick();
    expect_snap("arst_setup", 8'h08, 8'h80, 8'h20, 2'b01, 3'd3, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    expect_snap("arst_immediate", 8'h00, 8'h00, 8'h00, 2'b00, 3'd0, 1'b0, 1'b0);
    floor_btn_in = 8'h01;
    tick();
    floor_btn_in = 8'h00;
    rst = 1'b0;
    tick();
    expect_snap("arst_dropped", 8'h00, 8'h00, 8'h00, 2'b00, 3'd0, 1'b0, 1'b0);

    #20;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected snapshots unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
